// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with HS/VS/DE, DE-aligned coordinates and look-ahead DE.
// Config is shadow-latched only when a frame starts; all outputs are registered one clock after the counters.
module video_timing_gen #(
  parameter int CNT_W  = 12,
  parameter int AHEAD  = 2,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic             I_en,
  input  logic             I_mode,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  output logic             O_hs,
  output logic             O_vs,
  output logic             O_de,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_pre_de,
  output logic [CNT_W-1:0] O_pre_x,
  output logic [CNT_W-1:0] O_pre_y,
  output logic             O_fs,
  output logic             O_busy,
  output logic             O_cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] one = 1;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_ht, r_hs, r_hbp, r_hres, r_vt, r_vs, r_vbp, r_vres, r_h, r_v;
  logic [CNT_W+1:0] w_hsum, w_vsum;
  logic [CNT_W:0] w_hb, w_he, w_vb, w_ve, w_ha;
  logic w_legal, w_h_end, w_f_end, w_load, w_run, w_vin, w_de, w_pde;
  // Three-term sums get two extra bits so the legality compare can never wrap.
  assign w_hsum  = {2'b0, I_h_sync} + {2'b0, I_h_bporch} + {2'b0, I_h_res};
  assign w_vsum  = {2'b0, I_v_sync} + {2'b0, I_v_bporch} + {2'b0, I_v_res};
  assign w_legal = |I_h_sync && |I_h_res && {2'b0, I_h_total} >= w_hsum &&
                   |I_v_sync && |I_v_res && {2'b0, I_v_total} >= w_vsum;
  assign w_run   = r_state == RUN;
  assign w_h_end = r_h == r_ht - one;
  assign w_f_end = w_h_end && r_v == r_vt - one;
  always_comb begin
    w_load = 1'b0;
    w_next = r_state;
    w_load = w_run ? (w_f_end && !I_mode && I_en) : I_en;
    w_next = (!w_run || w_f_end) ? (w_load && w_legal ? RUN : IDLE) : RUN;
  end
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state   <= IDLE;
      r_h       <= '0;
      r_v       <= '0;
      O_cfg_err <= 1'b0;
      {r_ht, r_hs, r_hbp, r_hres, r_vt, r_vs, r_vbp, r_vres} <= '0;
    end else begin
      r_state <= w_next;
      r_h     <= (w_run && !w_f_end) ? (w_h_end ? '0 : r_h + one) : '0;
      r_v     <= (w_run && !w_f_end) ? (w_h_end ? r_v + one : r_v) : '0;
      if (w_load) begin
        O_cfg_err <= !w_legal;
        {r_ht, r_hs, r_hbp, r_hres} <= {I_h_total, I_h_sync, I_h_bporch, I_h_res};
        {r_vt, r_vs, r_vbp, r_vres} <= {I_v_total, I_v_sync, I_v_bporch, I_v_res};
      end
    end
  end
  assign w_hb  = {1'b0, r_hs} + {1'b0, r_hbp};
  assign w_he  = w_hb + {1'b0, r_hres};
  assign w_vb  = {1'b0, r_vs} + {1'b0, r_vbp};
  assign w_ve  = w_vb + {1'b0, r_vres};
  assign w_ha  = {1'b0, r_h} + (CNT_W+1)'(AHEAD);
  assign w_vin = {1'b0, r_v} >= w_vb && {1'b0, r_v} < w_ve;
  assign w_de  = w_run && w_vin && {1'b0, r_h} >= w_hb && {1'b0, r_h} < w_he;
  // Look-ahead column is not wrapped: past the line end it simply falls outside the active window.
  assign w_pde = w_run && w_vin && w_ha >= w_hb && w_ha < w_he;
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      O_hs     <= !HS_POL;
      O_vs     <= !VS_POL;
      O_de     <= 1'b0;
      O_x      <= '0;
      O_y      <= '0;
      O_pre_de <= 1'b0;
      O_pre_x  <= '0;
      O_pre_y  <= '0;
      O_fs     <= 1'b0;
      O_busy   <= 1'b0;
    end else begin
      O_hs     <= (w_run && r_h < r_hs) ? HS_POL : !HS_POL;
      O_vs     <= (w_run && r_v < r_vs) ? VS_POL : !VS_POL;
      O_de     <= w_de;
      O_x      <= w_de ? r_h - w_hb[CNT_W-1:0] : '0;
      O_y      <= w_de ? r_v - w_vb[CNT_W-1:0] : '0;
      O_pre_de <= w_pde;
      O_pre_x  <= w_pde ? w_ha[CNT_W-1:0] - w_hb[CNT_W-1:0] : '0;
      O_pre_y  <= w_pde ? r_v - w_vb[CNT_W-1:0] : '0;
      O_fs     <= w_run && r_h == '0 && r_v == '0;
      O_busy   <= w_run;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized and directed checks of video_timing_gen against a frame-level arithmetic model.
module tb_video_timing_gen;
  localparam int AHEAD = 2;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  typedef struct {int ht, hs, hbp, hres, vt, vs, vbp, vres;} cfg_t;
  logic clk = 0, rst = 1, en = 0, mode = 0;
  logic [11:0] h_total = 0, h_sync = 0, h_bporch = 0, h_res = 0;
  logic [11:0] v_total = 0, v_sync = 0, v_bporch = 0, v_res = 0;
  logic hs, vs, de, pre_de, fs, busy, cfg_err;
  logic [11:0] x, y, pre_x, pre_y;
  logic [54:0] obs;
  int checks = 0, errors = 0;
  cfg_t spec_cfg = '{16, 2, 3, 8, 6, 1, 1, 3};
  video_timing_gen #(.CNT_W(12), .AHEAD(AHEAD), .HS_POL(HS_POL), .VS_POL(VS_POL)) dut (
    .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_mode(mode),
    .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
    .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
    .O_hs(hs), .O_vs(vs), .O_de(de), .O_x(x), .O_y(y),
    .O_pre_de(pre_de), .O_pre_x(pre_x), .O_pre_y(pre_y),
    .O_fs(fs), .O_busy(busy), .O_cfg_err(cfg_err));
  always #5 clk = ~clk;
  assign obs = {hs, vs, de, x, y, pre_de, pre_x, pre_y, fs, busy, cfg_err};
  // Expected outputs for the k-th clock of a frame, straight from the raster rules.
  function automatic logic [54:0] exp_vec(input int k, input cfg_t c);
    int h, v, hb, vb, ha;
    logic d, pd, vin;
    h = k % c.ht;
    v = k / c.ht;
    hb = c.hs + c.hbp;
    vb = c.vs + c.vbp;
    ha = h + AHEAD;
    vin = v >= vb && v < vb + c.vres;
    d = vin && h >= hb && h < hb + c.hres;
    pd = vin && ha >= hb && ha < hb + c.hres;
    return {(h < c.hs) ? HS_POL : !HS_POL, (v < c.vs) ? VS_POL : !VS_POL,
            d, d ? 12'(h - hb) : 12'd0, d ? 12'(v - vb) : 12'd0,
            pd, pd ? 12'(ha - hb) : 12'd0, pd ? 12'(v - vb) : 12'd0,
            k == 0, 1'b1, 1'b0};
  endfunction
  function automatic logic [54:0] idle_vec(input logic err);
    return {!HS_POL, !VS_POL, 52'd0, err};
  endfunction
  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.hs = $urandom_range(1, 3);
    c.hbp = $urandom_range(2, 4);
    c.hres = $urandom_range(1, 8);
    c.ht = c.hs + c.hbp + c.hres + $urandom_range(0, 3);
    c.vs = $urandom_range(1, 2);
    c.vbp = $urandom_range(0, 2);
    c.vres = $urandom_range(1, 4);
    c.vt = c.vs + c.vbp + c.vres + $urandom_range(0, 2);
    return c;
  endfunction
  task automatic drive_cfg(input cfg_t c);
    {h_total, h_sync, h_bporch, h_res} = {12'(c.ht), 12'(c.hs), 12'(c.hbp), 12'(c.hres)};
    {v_total, v_sync, v_bporch, v_res} = {12'(c.vt), 12'(c.vs), 12'(c.vbp), 12'(c.vres)};
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, idle_vec(0)); end
    @(negedge clk) rst = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL reset_idle got %h exp %h", obs, idle_vec(0)); end
  endtask
  task automatic test_single_frame(input cfg_t c, input bit scramble);
    int n, de_cnt;
    n = c.ht * c.vt;
    de_cnt = 0;
    @(negedge clk);
    drive_cfg(c);
    mode = 1;
    en = 1;
    @(posedge clk);
    #1 en = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 checks++;
      if (obs !== exp_vec(k, c)) begin errors++; $display("FAIL frame k=%0d got %h exp %h", k, obs, exp_vec(k, c)); end
      de_cnt += int'(de);
      if (scramble) begin
        {h_total, h_sync, h_bporch, h_res} = {12'($urandom_range(0, 40)), 12'($urandom_range(0, 9)), 12'($urandom_range(0, 9)), 12'($urandom_range(0, 9))};
        {v_total, v_sync, v_bporch, v_res} = {12'($urandom_range(0, 40)), 12'($urandom_range(0, 9)), 12'($urandom_range(0, 9)), 12'($urandom_range(0, 9))};
      end
    end
    @(posedge clk);
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL frame_end_idle got %h exp %h", obs, idle_vec(0)); end
    checks++;
    if (de_cnt !== c.hres * c.vres) begin errors++; $display("FAIL de_count got %0d exp %0d", de_cnt, c.hres * c.vres); end
  endtask
  task automatic test_de_edge();
    @(negedge clk);
    drive_cfg(spec_cfg);
    mode = 1;
    en = 1;
    @(posedge clk);
    #1 en = 0;
    for (int k = 0; k < 96; k++) begin
      @(posedge clk);
      #1;
      if (k == 35) begin
        checks++;
        if ({pre_de, pre_x, pre_y, de} !== {1'b1, 24'd0, 1'b0}) begin errors++; $display("FAIL pre_de_lead got %b/%0d/%0d de=%b exp 1/0/0 de=0", pre_de, pre_x, pre_y, de); end
      end
      if (k == 37) begin
        checks++;
        if ({de, x, y} !== {1'b1, 24'd0}) begin errors++; $display("FAIL de_rise got %b/%0d/%0d exp 1/0/0", de, x, y); end
      end
    end
    repeat (2) @(posedge clk);
  endtask
  task automatic test_back_to_back(input cfg_t a, input cfg_t b, input int change_k);
    int na, nb, fs_cnt;
    logic [54:0] e;
    na = a.ht * a.vt;
    nb = b.ht * b.vt;
    fs_cnt = 0;
    @(negedge clk);
    drive_cfg(a);
    mode = 0;
    en = 1;
    @(posedge clk);
    for (int k = 0; k < na + nb; k++) begin
      @(posedge clk);
      #1 e = (k < na) ? exp_vec(k, a) : exp_vec(k - na, b);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b k=%0d got %h exp %h", k, obs, e); end
      fs_cnt += int'(fs);
      if (k == change_k) drive_cfg(b);
      if (k == na + 2 * b.ht) en = 0;
    end
    @(posedge clk);
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL b2b_stop got %h exp %h", obs, idle_vec(0)); end
    checks++;
    if (fs_cnt !== 2) begin errors++; $display("FAIL fs_count got %0d exp 2", fs_cnt); end
  endtask
  task automatic test_cfg_err();
    cfg_t bad;
    bad = spec_cfg;
    bad.ht = 10;
    @(negedge clk);
    drive_cfg(bad);
    mode = 0;
    en = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 checks++;
      if (obs !== idle_vec(1)) begin errors++; $display("FAIL cfg_err k=%0d got %h exp %h", k, obs, idle_vec(1)); end
    end
    @(negedge clk);
    en = 0;
    drive_cfg(spec_cfg);
    mode = 1;
    en = 1;
    @(posedge clk);
    #1 en = 0;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got %b exp 0", cfg_err); end
    repeat (98) @(posedge clk);
  endtask
  task automatic test_rst_midline();
    @(negedge clk);
    drive_cfg(spec_cfg);
    mode = 1;
    en = 1;
    @(posedge clk);
    #1 en = 0;
    repeat (40) @(posedge clk);
    #1 checks++;
    if ({hs, de, busy} !== {!HS_POL, 1'b1, 1'b1}) begin errors++; $display("FAIL pre_reset got hs=%b de=%b busy=%b exp %b/1/1", hs, de, busy, !HS_POL); end
    #2 rst = 1;
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL async_reset got %h exp %h", obs, idle_vec(0)); end
    @(negedge clk) rst = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (obs !== idle_vec(0)) begin errors++; $display("FAIL post_reset got %h exp %h", obs, idle_vec(0)); end
  endtask
  initial begin
    cfg_t b;
    test_reset();
    test_single_frame(spec_cfg, 1'b0);
    test_de_edge();
    b = spec_cfg;
    b.hres = 6;
    test_back_to_back(spec_cfg, b, 40);
    test_cfg_err();
    test_rst_midline();
    for (int i = 0; i < 6; i++) test_single_frame(rand_cfg(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cfg_t a;
      a = rand_cfg();
      test_back_to_back(a, rand_cfg(), $urandom_range(0, a.ht * a.vt - 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
